// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, destination field positions,
// packet layout and buffer occupancy states.
package noc_pkg;

    localparam int unsigned PKT_WIDTH = 39;
    localparam int unsigned X_MSB     = 36;
    localparam int unsigned X_LSB     = 33;
    localparam int unsigned Y_MSB     = 32;
    localparam int unsigned Y_LSB     = 29;

    // Packet layout: [38:37] reserved, [36:33] dest x, [32:29] dest y, [28:0] payload
    typedef struct packed {
        logic [1:0]  rsvd;
        logic [3:0]  dest_x;
        logic [3:0]  dest_y;
        logic [28:0] payload;
    } pkt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, wrapping mod NUM_IN;
// the first requester wins.
// Ports:
//   req      - request vector
//   ptr      - current search start index
//   grant    - one-hot grant (all zero when no request)
//   next_ptr - index after the winner, or ptr when nothing is granted
module rr_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [PTR_W-1:0]  next_ptr
);

    // Rotating first-one search
    always_comb begin
        int unsigned idx;
        logic        found;
        logic [PTR_W-1:0] sel;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = (32'(ptr) + k) % NUM_IN;
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NUM_IN);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Merges NUM_IN switch outputs onto one link: round-robin grant into a
// DEPTH-entry output FIFO whose head drives the link.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   in_valid     - per-input packet offered
//   in_data      - per-input packet, slice [i*WIDTH +: WIDTH]
//   in_ready     - per-input grant (combinational, at most one high)
//   out_valid    - FIFO head valid
//   out_data     - FIFO head packet, straight from storage
//   out_ready    - downstream accepts head
//   grant_cnt    - per-input saturating 16-bit accept counters
//                  (present only when PORT_ARBITER_STATS_EN is defined)
module port_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH  = PKT_WIDTH,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready
`ifdef PORT_ARBITER_STATS_EN
    ,
    output logic [NUM_IN*16-1:0]    grant_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] grant;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  push_data;
    logic              push;
    logic              pop;
    logic              full;
    occ_t              occ;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Occupancy decode
    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == CW'(DEPTH))
            occ = OCC_FULL;
    end

    assign full = (occ == OCC_FULL);

    // No grants when full (no pass-through) or while reset is held
    assign req = in_valid & {NUM_IN{~full & rst_n}};

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign in_ready  = grant;
    assign push      = |grant;
    assign out_valid = (occ != OCC_EMPTY);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;

    // Select the granted input's packet
    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i])
                push_data = push_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    // Arbitration pointer and FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ptr    <= next_ptr;
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage is not reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

`ifdef PORT_ARBITER_STATS_EN
    // Per-input saturating accept counters
    for (genvar g = 0; g < NUM_IN; g++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (grant[g] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[g*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed table, model-checked
// sequences and randomized traffic against a queue-based reference.
module tb_port_arbiter;

    localparam int unsigned W  = 39;
    localparam int unsigned NI = 4;
    localparam int unsigned D  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   in_valid;
    logic [NI*W-1:0] in_data;
    logic [NI-1:0]   in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;
`ifdef PORT_ARBITER_STATS_EN
    logic [NI*16-1:0] grant_cnt;
`endif

    port_arbiter #(.WIDTH(W), .NUM_IN(NI), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PORT_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: packet queue plus round-robin start index
    logic [W-1:0] q[$];
    int           mptr;

    typedef struct {
        logic          do_rst;
        logic [NI-1:0] valid;
        logic          ord;
        logic [NI-1:0] exp_ready;
        logic          exp_ov;
        logic [W-1:0]  exp_data;
    } vec_t;

    vec_t         tbl[15];
    logic [W-1:0] pk[NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        mptr = 0;
    endtask

    // One model-checked cycle with inputs already driven
    task automatic model_cycle(input string tag);
        logic [NI-1:0] eg;
        int            g;
        eg = '0;
        g  = -1;
        @(negedge clk);
        if (q.size() < D) begin
            for (int k = 0; k < NI; k++) begin
                int idx;
                idx = (mptr + k) % NI;
                if (g < 0 && in_valid[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(eg));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0)
            check({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
        @(posedge clk);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(in_data[g*W +: W]);
            mptr = (g + 1) % NI;
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NI; i++)
            in_data[i*W +: W] = W'({$urandom(), $urandom()});
    endtask

    initial begin
        pk[0] = 39'h1_0000_0A00;
        pk[1] = 39'h0_1111_0001;
        pk[2] = 39'h0_2222_1111;
        pk[3] = 39'h3_3333_0003;

        // single input 2 into empty buffer
        tbl[0]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, '0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, pk[2]};
        tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, '0};
        // inputs 1 and 3, out_ready low: fill, hold while full, drain
        tbl[3]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 1'b0, '0};
        tbl[4]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, pk[1]};
        tbl[5]  = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, pk[1]};
        tbl[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0000, 1'b1, pk[1]};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, pk[3]};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, '0};
        // all inputs valid, streaming
        tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, '0};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, pk[0]};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, pk[1]};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, pk[2]};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, pk[3]};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, pk[0]};

        in_data = '0;
        rst_n   = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        #2;
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.in_ready", 64'(in_ready), 64'(0));
        in_valid = 4'b1111;
        #1;
        check("reset.in_ready_held", 64'(in_ready), 64'(0));

        for (int i = 0; i < NI; i++) in_data[i*W +: W] = pk[i];

        // Directed table
        foreach (tbl[r]) begin
            if (tbl[r].do_rst) begin
                do_reset();
                for (int i = 0; i < NI; i++) in_data[i*W +: W] = pk[i];
            end
            in_valid  = tbl[r].valid;
            out_ready = tbl[r].ord;
            @(negedge clk);
            check($sformatf("tbl%0d.in_ready", r), 64'(in_ready), 64'(tbl[r].exp_ready));
            check($sformatf("tbl%0d.out_valid", r), 64'(out_valid), 64'(tbl[r].exp_ov));
            if (tbl[r].exp_ov)
                check($sformatf("tbl%0d.out_data", r), 64'(out_data), 64'(tbl[r].exp_data));
            @(posedge clk);
            #1;
        end

        // count stays 1 with push and pop every cycle, fresh data each cycle
        do_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            rand_data();
            model_cycle("pushpop");
            if (c > 0) check("pushpop.count", 64'(q.size()), 64'(1));
        end

        // asynchronous reset while full
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        rand_data();
        model_cycle("fill");
        model_cycle("fill");
        check("fill.full", 64'(q.size()), 64'(D));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid", 64'(out_valid), 64'(0));
        check("async_rst.in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        mptr = 0;
        model_cycle("after_rst");

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            in_valid  = NI'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            model_cycle("rand");
        end

`ifdef PORT_ARBITER_STATS_EN
        // saturating counter for input 0
        do_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(negedge clk);
        check("stats.cnt0", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
        check("stats.others", 64'(grant_cnt[NI*16-1:16]), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 39, packet width (bits [36:33] = dest x, [32:29] = dest y).
REQ-002 SHALL have parameter NUM_IN, default 4, number of switch outputs merged onto one link.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries.
REQ-004 SHALL have port clk, input, 1, the single clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, NUM_IN, packet offered by switch i.
REQ-007 SHALL have port in_data, input, NUM_IN*WIDTH, packet of switch i in slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready, output, NUM_IN, grant/accept for switch i.
REQ-009 SHALL have port out_valid, output, 1, buffer head valid toward the link or next router.
REQ-010 SHALL have port out_data, output, WIDTH, buffer head packet.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts head.

Function
REQ-012 SHALL transfer input i on cycles where in_valid[i] and in_ready[i] are both high; the output SHALL transfer on cycles where out_valid and out_ready are both high.
REQ-013 SHALL assert at most one in_ready bit per cycle; in_ready[i] = 1 only if in_valid[i] = 1, i wins round-robin arbitration, and occupancy < DEPTH.
REQ-014 Round-robin: the search starts at pointer ptr and runs ptr, ptr+1, ... mod NUM_IN; the first valid index wins.
REQ-015 After a grant to index g, ptr SHALL become (g+1) mod NUM_IN; with no grant, ptr SHALL hold.
REQ-016 Buffer: circular FIFO of DEPTH entries with rd_ptr, wr_ptr, count 0..DEPTH; occupancy states EMPTY (0), PARTIAL, FULL (DEPTH).
REQ-017 out_valid = (count != 0); out_data = the entry at rd_ptr, driven directly from storage.
REQ-018 Latency: a packet accepted in cycle N SHALL appear on out_data with out_valid in cycle N+1 if the buffer was empty.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 When FULL, all in_ready SHALL be low even if out_ready is high in the same cycle; no pass-through when full.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-022 Packets SHALL NOT be modified or reordered; FIFO order equals grant order.
REQ-023 Once out_valid is high, out_data SHALL stay stable until popped.

Reset
REQ-024 While rst_n = 0: count = 0, rd_ptr = wr_ptr = 0, ptr = 0, out_valid = 0, in_ready = 0; FIFO storage is not cleared.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered packets immediately; the first grant after release goes to the lowest valid index from ptr 0.

Configuration
REQ-026 Macro PORT_ARBITER_STATS_EN: when defined, the module SHALL add output grant_cnt (NUM_IN*16) with one saturating 16-bit counter per input, incremented on each accepted transfer, cleared by reset, holding at 16'hFFFF.
REQ-027 Without PORT_ARBITER_STATS_EN, neither grant_cnt nor its counters SHALL exist, and all other behaviour is identical.

Structure
REQ-028 Shared package noc_pkg SHALL hold PKT_WIDTH = 39, the field-position constants (X_MSB/LSB = 36/33, Y_MSB/LSB = 32/29), and typedef pkt_t.
REQ-029 Arbitration SHALL be a separate sub-module rr_arbiter (request vector in; one-hot grant and pointer update out); the FIFO stays inline.

Verification
REQ-030 The bench SHALL check: single input 2 drives valid with 39'h0_2222_1111 into an empty buffer, out_ready = 1 -> in_ready[2] = 1 that cycle, out_valid = 1 with the same data next cycle.
REQ-031 The bench SHALL check: all four inputs valid continuously, out_ready = 1 -> grants 0, 1, 2, 3, 0, ... one per cycle and output order matches.
REQ-032 The bench SHALL check: out_ready = 0, inputs 1 and 3 valid -> two grants (1 then 3), then in_ready = 0 while FULL; releasing out_ready pops 1 then 3.
REQ-033 The bench SHALL check: count = 1 with push and pop in the same cycle -> count stays 1 and data order is preserved over 10 cycles.
REQ-034 The bench SHALL check: rst_n pulled low while FULL -> out_valid = 0 within the same timestep (asynchronous), and the next grant after release is to input 0 when all inputs are valid.
REQ-035 The bench SHALL check, with PORT_ARBITER_STATS_EN: 70000 grants to input 0 -> grant_cnt[15:0] = 16'hFFFF and the other counters = 0.
